// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel plus the valid/ready handoff to decode.
// The master modport is the fetch unit; slave is the memory/decode side.
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_out, pc_out, pc_plus4, inst_valid,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_out, pc_out, pc_plus4, inst_valid,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: owns the PC, fetches words over req/ack, hands them to decode, honours jump/branch redirects.
// Latency: imem_ack -> inst_valid one cycle. Backpressure: inst_valid holds until inst_ready; no new request meanwhile.
// A request left unacknowledged for WAIT_MAX cycles raises sticky fetch_err and parks the unit until reset.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                 clk_CPU,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 jump,
  input  logic [25:0]          jump_target,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic                 fetch_err,
  mips_fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t             state;
  logic [31:0]        pc;
  logic [31:0]        pc_out_q;
  logic [31:0]        inst_q;
  logic               inst_valid_q;
  logic               req_q;
  logic               flush;
  logic [CNT_W-1:0]   wait_cnt;

  logic               redirect;
  logic [31:0]        pc_inc;
  logic [31:0]        pc_out_plus4;
  logic [31:0]        redirect_pc;

  assign pc_inc       = pc + 32'd4;
  assign pc_out_plus4 = pc_out_q + 32'd4;
  assign redirect     = jump | branch_taken;

  // Jump region bits come from the instruction being decoded (pc_out + 4).
  always_comb begin
    redirect_pc = {branch_target[31:2], 2'b00};
    if (jump) begin
      redirect_pc = {pc_out_plus4[31:28], jump_target, 2'b00};
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc;
  assign bus.inst_out   = inst_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.pc_plus4   = pc_out_plus4;
  assign bus.inst_valid = inst_valid_q;

  always_ff @(posedge clk_CPU or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      pc_out_q     <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
      flush        <= 1'b0;
      wait_cnt     <= '0;
      fetch_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= redirect_pc;
          end
          if (run && !fetch_err) begin
            state    <= REQ;
            req_q    <= 1'b1;
            wait_cnt <= '0;
          end
        end

        REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
          end
          if (req_q) begin
            if (bus.imem_ack) begin
              req_q    <= 1'b0;
              wait_cnt <= '0;
              if (flush || redirect) begin
                // Stale word: drop it and re-request the redirected pc next cycle.
                flush <= 1'b0;
              end else begin
                inst_q       <= bus.imem_rdata;
                pc_out_q     <= pc;
                inst_valid_q <= 1'b1;
                state        <= HOLD;
              end
            end else if (wait_cnt == WAIT_LAST) begin
              req_q     <= 1'b0;
              flush     <= 1'b0;
              fetch_err <= 1'b1;
              state     <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
              if (redirect) begin
                flush <= 1'b1;
              end
            end
          end else begin
            req_q    <= 1'b1;
            wait_cnt <= '0;
          end
        end

        HOLD: begin
          if (redirect) begin
            inst_valid_q <= 1'b0;
            pc           <= redirect_pc;
            state        <= REQ;
            req_q        <= 1'b1;
            wait_cnt     <= '0;
          end else if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            pc           <= pc_inc;
            if (run) begin
              state    <= REQ;
              req_q    <= 1'b1;
              wait_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios plus a randomized run checked against a transaction-level PC model.
module tb_mips_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          WAIT_MAX = 16;

  logic        clk_CPU = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        fetch_err;

  int tests_run = 0;
  int failed = 0;

  mips_fetch_unit_if bus ();

  mips_fetch_unit #(
    .RESET_PC (RESET_PC),
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (5)
  ) dut (
    .clk_CPU       (clk_CPU),
    .rst_n         (rst_n),
    .run           (run),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_err     (fetch_err),
    .bus           (bus)
  );

  always #5 clk_CPU = ~clk_CPU;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Inputs change just after the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk_CPU);
    @(negedge clk_CPU);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = '0; branch_target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({bus.imem_req, bus.inst_valid, fetch_err, bus.imem_addr, bus.inst_out, bus.pc_out, bus.pc_plus4}
          !== {3'b000, RESET_PC, 32'h0, RESET_PC, RESET_PC + 32'd4}) begin
        failed++;
        $display("FAIL reset_state: got req=%b vld=%b err=%b addr=%h inst=%h pc=%h pc4=%h want 0,0,0,%h,0,%h,%h",
                 bus.imem_req, bus.inst_valid, fetch_err, bus.imem_addr, bus.inst_out, bus.pc_out,
                 bus.pc_plus4, RESET_PC, RESET_PC, RESET_PC + 32'd4);
      end
      step();
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    bus.inst_ready = 1'b1;
    run = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      a = RESET_PC + 32'(i * 4);
      tests_run++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, a}) begin
        failed++;
        $display("FAIL seq_req: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, a);
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(a);
      step();
      bus.imem_ack = 1'b0; bus.imem_rdata = $urandom;
      tests_run++;
      if ({bus.inst_valid, bus.imem_req, bus.inst_out, bus.pc_out, bus.pc_plus4}
          !== {2'b10, mem_word(a), a, a + 32'd4}) begin
        failed++;
        $display("FAIL seq_handoff: got vld=%b req=%b inst=%h pc=%h pc4=%h want 1,0,%h,%h,%h",
                 bus.inst_valid, bus.imem_req, bus.inst_out, bus.pc_out, bus.pc_plus4,
                 mem_word(a), a, a + 32'd4);
      end
      step();
    end
  endtask

  task automatic test_wait_backpressure();
    do_reset();
    run = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
        failed++;
        $display("FAIL wait_req_hold: got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr);
      end
      step();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h0);
    step();
    bus.imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bus.inst_ready = 1'b1;
      tests_run++;
      if ({bus.inst_valid, bus.imem_req, bus.inst_out, bus.pc_out} !== {2'b10, mem_word(32'h0), 32'h0}) begin
        failed++;
        $display("FAIL hold_stable: got vld=%b req=%b inst=%h pc=%h want 1,0,%h,0",
                 bus.inst_valid, bus.imem_req, bus.inst_out, bus.pc_out, mem_word(32'h0));
      end
      step();
    end
    bus.inst_ready = 1'b0;
    // Two fetches each acked on the last allowed cycle: the counter must restart per request.
    for (int n = 1; n <= 2; n++) begin
      for (int k = 0; k < WAIT_MAX - 1; k++) begin
        tests_run++;
        if ({bus.imem_req, fetch_err, bus.imem_addr} !== {2'b10, 32'(n * 4)}) begin
          failed++;
          $display("FAIL wait_edge_req: got req=%b err=%b addr=%h want 1,0,%h",
                   bus.imem_req, fetch_err, bus.imem_addr, 32'(n * 4));
        end
        step();
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'(n * 4));
      step();
      bus.imem_ack = 1'b0;
      tests_run++;
      if ({bus.inst_valid, fetch_err, bus.pc_out, bus.inst_out} !== {2'b10, 32'(n * 4), mem_word(32'(n * 4))}) begin
        failed++;
        $display("FAIL wait_edge_ack: got vld=%b err=%b pc=%h inst=%h want 1,0,%h,%h",
                 bus.inst_valid, fetch_err, bus.pc_out, bus.inst_out, 32'(n * 4), mem_word(32'(n * 4)));
      end
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
    end
  endtask

  task automatic test_jump_flush();
    do_reset();
    run = 1'b1; bus.inst_ready = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'(i * 4));
      step();
      bus.imem_ack = 1'b0;
      step();
    end
    jump = 1'b1; jump_target = 26'h0000010;
    step();
    jump = 1'b0;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_0040}) begin
      failed++;
      $display("FAIL jump_addr: got req=%b addr=%h want req=1 addr=00000040", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h8);
    step();
    bus.imem_ack = 1'b0;
    tests_run++;
    if ({bus.inst_valid, bus.imem_req} !== 2'b00) begin
      failed++;
      $display("FAIL jump_discard: got vld=%b req=%b want 0,0", bus.inst_valid, bus.imem_req);
    end
    step();
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_0040}) begin
      failed++;
      $display("FAIL jump_rereq: got req=%b addr=%h want req=1 addr=00000040", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h40);
    step();
    bus.imem_ack = 1'b0;
    tests_run++;
    if ({bus.inst_valid, bus.pc_out, bus.inst_out} !== {1'b1, 32'h40, mem_word(32'h40)}) begin
      failed++;
      $display("FAIL jump_handoff: got vld=%b pc=%h inst=%h want 1,00000040,%h",
               bus.inst_valid, bus.pc_out, bus.inst_out, mem_word(32'h40));
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    jump = 1'b1; jump_target = 26'h20; branch_taken = 1'b1; branch_target = 32'h500;
    step();
    jump = 1'b0;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h80}) begin
      failed++;
      $display("FAIL prio_jump_wins: got req=%b addr=%h want req=0 addr=00000080", bus.imem_req, bus.imem_addr);
    end
    branch_target = 32'h103;
    step();
    branch_taken = 1'b0;
    tests_run++;
    if (bus.imem_addr !== 32'h100) begin
      failed++;
      $display("FAIL branch_mask: got addr=%h want 00000100", bus.imem_addr);
    end
    run = 1'b1;
    step();
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h100);
    step();
    bus.imem_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h3000_0002;
    step();
    branch_taken = 1'b0;
    tests_run++;
    if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h3000_0000}) begin
      failed++;
      $display("FAIL hold_branch: got vld=%b req=%b addr=%h want 0,1,30000000",
               bus.inst_valid, bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h3000_0000);
    step();
    bus.imem_ack = 1'b0;
    jump = 1'b1; jump_target = 26'h5;
    step();
    jump = 1'b0;
    tests_run++;
    if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h3000_0014}) begin
      failed++;
      $display("FAIL hold_jump_region: got vld=%b req=%b addr=%h want 0,1,30000014",
               bus.inst_valid, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1'b1;
    step();
    for (int k = 0; k < WAIT_MAX; k++) begin
      tests_run++;
      if ({bus.imem_req, fetch_err} !== 2'b10) begin
        failed++;
        $display("FAIL timeout_wait: cycle %0d got req=%b err=%b want 1,0", k, bus.imem_req, fetch_err);
      end
      step();
    end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if ({bus.imem_req, fetch_err, bus.inst_valid} !== 3'b010) begin
        failed++;
        $display("FAIL timeout_parked: got req=%b err=%b vld=%b want 0,1,0", bus.imem_req, fetch_err, bus.inst_valid);
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (fetch_err !== 1'b0) begin
      failed++;
      $display("FAIL timeout_clear: got err=%b want 0", fetch_err);
    end
    @(negedge clk_CPU);
    rst_n = 1'b1;
    step();
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, RESET_PC}) begin
      failed++;
      $display("FAIL timeout_restart: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0; run = 1'b1;
    step();
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'hFFFF_FFFC);
    step();
    bus.imem_ack = 1'b0;
    tests_run++;
    if ({bus.inst_valid, bus.pc_out, bus.pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      failed++;
      $display("FAIL wrap_pc4: got vld=%b pc=%h pc4=%h want 1,fffffffc,00000000",
               bus.inst_valid, bus.pc_out, bus.pc_plus4);
    end
    bus.inst_ready = 1'b1;
    step();
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      failed++;
      $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=00000000", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h0);
    step();
    bus.imem_ack = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.imem_req, bus.inst_valid, fetch_err, bus.imem_addr, bus.inst_out, bus.pc_out, bus.pc_plus4}
        !== {3'b000, RESET_PC, 32'h0, RESET_PC, RESET_PC + 32'd4}) begin
      failed++;
      $display("FAIL async_reset: got req=%b vld=%b err=%b addr=%h inst=%h pc=%h pc4=%h",
               bus.imem_req, bus.inst_valid, fetch_err, bus.imem_addr, bus.inst_out, bus.pc_out, bus.pc_plus4);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h4);
    @(negedge clk_CPU);
    step();
    bus.imem_ack = 1'b0;
    tests_run++;
    if ({bus.inst_valid, bus.imem_req} !== 2'b00) begin
      failed++;
      $display("FAIL late_ack_ignored: got vld=%b req=%b want 0,0", bus.inst_valid, bus.imem_req);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, mem_addr;
    logic        mem_busy, handoff;
    int          mem_lat, stall, handoffs;
    int unsigned r;
    do_reset();
    run = 1'b1;
    exp_pc = RESET_PC; mem_addr = '0; mem_busy = 1'b0; mem_lat = 0; stall = 0; handoffs = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.imem_req) begin
        tests_run++;
        if (bus.imem_addr !== exp_pc) begin
          failed++;
          $display("FAIL rnd_addr: cycle %0d got %h want %h", c, bus.imem_addr, exp_pc);
        end
      end
      if (bus.inst_valid) begin
        tests_run++;
        if ({bus.pc_out, bus.inst_out} !== {exp_pc, mem_word(exp_pc)}) begin
          failed++;
          $display("FAIL rnd_handoff: cycle %0d got pc=%h inst=%h want pc=%h inst=%h",
                   c, bus.pc_out, bus.inst_out, exp_pc, mem_word(exp_pc));
        end
      end
      // Memory answers the address it saw when the request started, after 0-3 cycles.
      bus.imem_ack = 1'b0; bus.imem_rdata = $urandom;
      if (bus.imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1; mem_lat = $urandom_range(0, 3); mem_addr = bus.imem_addr;
        end
        if (mem_lat == 0) begin
          bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(mem_addr); mem_busy = 1'b0;
        end else begin
          mem_lat--;
        end
      end
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 39);
      jump = (r < 2);
      branch_taken = (r >= 1 && r < 4);
      jump_target = 26'($urandom_range(0, 32'h00FF_FFFF));
      branch_target = $urandom & 32'h03FF_FFFF;
      handoff = 1'b0;
      // All random addresses stay below 0x1000_0000, so the jump region bits are zero.
      if (jump) exp_pc = {4'h0, jump_target, 2'b00};
      else if (branch_taken) exp_pc = {branch_target[31:2], 2'b00};
      else if (bus.inst_valid && bus.inst_ready) begin
        exp_pc = exp_pc + 32'd4;
        handoff = 1'b1;
      end
      if (handoff) begin
        handoffs++; stall = 0;
      end else begin
        stall++;
      end
      step();
      if (stall > 200) begin
        tests_run++; failed++;
        $display("FAIL rnd_stall: no handoff for %0d cycles at cycle %0d", stall, c);
        break;
      end
    end
    jump = 1'b0; branch_taken = 1'b0; bus.imem_ack = 1'b0;
    tests_run++;
    if (handoffs < 100) begin
      failed++;
      $display("FAIL rnd_progress: got %0d handoffs want at least 100", handoffs);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_backpressure();
    test_jump_flush();
    test_redirect_priority();
    test_timeout();
    test_wrap_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
